// File: rtl/mode_scheduler_if.sv
// Bundle of the scheduler's button, event and display-select signals.
// master drives the debounced inputs; slave is the scheduler itself.
interface mode_scheduler_if;
  logic       tick_1hz;
  logic [2:0] mode_pulse;
  logic       edit_lvl;
  logic [3:0] nav_pulse;
  logic       timer_done;
  logic       alarm_hit;
  logic [1:0] mode;
  logic [3:0] mode_oh;
  logic [3:0] edit_en;
  logic [3:0] nav_out;
  logic       alert_active;
  logic [1:0] alert_src;

  modport master (
    output tick_1hz, mode_pulse, edit_lvl, nav_pulse, timer_done, alarm_hit,
    input  mode, mode_oh, edit_en, nav_out, alert_active, alert_src
  );
  modport slave (
    input  tick_1hz, mode_pulse, edit_lvl, nav_pulse, timer_done, alarm_hit,
    output mode, mode_oh, edit_en, nav_out, alert_active, alert_src
  );
endinterface

// File: rtl/mode_scheduler.sv
// Mode sequencer for the digital clock: grants display/edit/nav to one of
// CLOCK/TIMER/STOPWATCH/ALARM and pre-empts with a timed ALERT on events.
module mode_scheduler #(
  parameter int ALERT_SEC = 10
) (
  input  logic            clk,
  input  logic            rst,
  mode_scheduler_if.slave bus
);
  localparam int CW = $clog2(ALERT_SEC + 1);

  typedef enum logic [2:0] {S_CLK, S_TMR, S_SW, S_ALM, S_ALERT} state_t;

  state_t          state_q, state_n;
  logic [1:0]      ret_q, ret_n;
  logic [1:0]      src_q, src_n;
  logic [CW-1:0]   cnt_q, cnt_n, cnt_dec;
  logic            pend_t_q, pend_t_n, pend_a_q, pend_a_n;
  logic            edit_q;
  logic [3:0]      edit_en_q, edit_en_n;
  logic [3:0]      nav_q, nav_n;
  logic [1:0]      mode_q, mode_n;
  logic [3:0]      mode_oh_q;
  logic            alert_q;
  logic            edit_rise, ack, rep, any_evt;
  logic [1:0]      sel, cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLK;
      ret_q     <= 2'b00;
      src_q     <= 2'b00;
      cnt_q     <= '0;
      pend_t_q  <= 1'b0;
      pend_a_q  <= 1'b0;
      edit_q    <= 1'b0;
      edit_en_q <= 4'b0000;
      nav_q     <= 4'b0000;
      mode_q    <= 2'b00;
      mode_oh_q <= 4'b0001;
      alert_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      ret_q     <= ret_n;
      src_q     <= src_n;
      cnt_q     <= cnt_n;
      pend_t_q  <= pend_t_n;
      pend_a_q  <= pend_a_n;
      edit_q    <= bus.edit_lvl;
      edit_en_q <= edit_en_n;
      nav_q     <= nav_n;
      mode_q    <= mode_n;
      mode_oh_q <= 4'b0001 << mode_n;
      alert_q   <= (state_n == S_ALERT);
    end
  end

  always_comb begin
    state_n   = state_q;
    ret_n     = ret_q;
    src_n     = src_q;
    cnt_n     = cnt_q;
    pend_t_n  = pend_t_q | bus.timer_done;
    pend_a_n  = pend_a_q | bus.alarm_hit;
    edit_en_n = 4'b0000;
    nav_n     = 4'b0000;
    sel       = 2'b00;
    cur       = state_q[1:0];
    edit_rise = bus.edit_lvl & ~edit_q;
    ack       = (|bus.mode_pulse) | (|bus.nav_pulse);
    any_evt   = pend_a_q | bus.alarm_hit | pend_t_q | bus.timer_done;
    rep       = 1'b0;
    cnt_dec   = (bus.tick_1hz && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    if (state_q == S_ALERT) begin
      // A repeat from the alerting source restarts the timeout instead of pending.
      if (src_q == 2'b10 && bus.alarm_hit) begin rep = 1'b1; pend_a_n = pend_a_q; end
      if (src_q == 2'b01 && bus.timer_done) begin rep = 1'b1; pend_t_n = pend_t_q; end
      if (ack || (!rep && cnt_dec == '0)) begin
        state_n = state_t'({1'b0, ret_q});
        src_n   = 2'b00;
        cnt_n   = '0;
      end else if (rep) begin
        cnt_n = CW'(ALERT_SEC);
      end else begin
        cnt_n = cnt_dec;
      end
    end else begin
      nav_n = (edit_en_q != 4'b0000 || state_q == S_SW) ? bus.nav_pulse : 4'b0000;
      if (any_evt && !bus.edit_lvl && edit_en_q == 4'b0000) begin
        state_n = S_ALERT;
        ret_n   = cur;
        cnt_n   = CW'(ALERT_SEC);
        // Clear only the served request; a fresh event on top of it stays pending.
        if (pend_a_q | bus.alarm_hit) begin
          src_n    = 2'b10;
          pend_a_n = pend_a_q & bus.alarm_hit;
        end else begin
          src_n    = 2'b01;
          pend_t_n = pend_t_q & bus.timer_done;
        end
      end else if (!bus.edit_lvl) begin
        for (int i = 2; i >= 0; i--)
          if (bus.mode_pulse[i]) sel = 2'(i + 1);
        if (|bus.mode_pulse)
          state_n = (cur == sel) ? S_CLK : state_t'({1'b0, sel});
      end else if (state_q != S_SW) begin
        edit_en_n = edit_rise ? (4'b0001 << cur) : edit_en_q;
      end
    end

    if (state_n == S_ALERT) mode_n = (src_n == 2'b10) ? 2'b11 : 2'b01;
    else                    mode_n = state_n[1:0];
  end

  assign bus.mode         = mode_q;
  assign bus.mode_oh      = mode_oh_q;
  assign bus.edit_en      = edit_en_q;
  assign bus.nav_out      = nav_q;
  assign bus.alert_active = alert_q;
  assign bus.alert_src    = src_q;
endmodule

// File: tb/tb_mode_scheduler.sv
// Directed bench for mode_scheduler: each step queues its expected outputs,
// then pops and compares them one cycle later.
module tb_mode_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;
  exp_t sb[$];

  mode_scheduler_if bus ();
  mode_scheduler #(.ALERT_SEC(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [16:0] pack(input logic [1:0] m, input logic [3:0] ee,
                                       input logic [3:0] no, input logic aa, input logic [1:0] as);
    logic [3:0] oh;
    oh = 4'b0001 << m;
    return {m, oh, ee, no, aa, as};
  endfunction

  task automatic push_exp(input string tag, input logic [1:0] m, input logic [3:0] ee,
                          input logic [3:0] no, input logic aa, input logic [1:0] as);
    exp_t e;
    e.tag = tag;
    e.v   = pack(m, ee, no, aa, as);
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t        e;
    logic [16:0] obs;
    obs = {bus.mode, bus.mode_oh, bus.edit_en, bus.nav_out, bus.alert_active, bus.alert_src};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  // Apply one cycle of inputs, queue the expected registered outputs, compare after the edge.
  task automatic step(input string tag, input logic [2:0] mp, input logic el, input logic [3:0] np,
                      input logic tk, input logic td, input logic ah,
                      input logic [1:0] m, input logic [3:0] ee, input logic [3:0] no,
                      input logic aa, input logic [1:0] as);
    bus.mode_pulse = mp;
    bus.edit_lvl   = el;
    bus.nav_pulse  = np;
    bus.tick_1hz   = tk;
    bus.timer_done = td;
    bus.alarm_hit  = ah;
    push_exp(tag, m, ee, no, aa, as);
    @(posedge clk);
    #1;
    pop_cmp();
    bus.mode_pulse = 3'b000;
    bus.nav_pulse  = 4'b0000;
    bus.tick_1hz   = 1'b0;
    bus.timer_done = 1'b0;
    bus.alarm_hit  = 1'b0;
  endtask

  initial begin
    bus.mode_pulse = 3'b000;
    bus.edit_lvl   = 1'b0;
    bus.nav_pulse  = 4'b0000;
    bus.tick_1hz   = 1'b0;
    bus.timer_done = 1'b0;
    bus.alarm_hit  = 1'b0;
    @(posedge clk);
    #1;
    push_exp("reset", 2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    pop_cmp();
    rst = 1'b0;

    //   tag            mp      el    np       tk    td    ah      mode   edit  nav   act   src
    step("sel_tmr",     3'b001, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b01, 4'h0, 4'h0, 1'b0, 2'b00);
    step("tmr_again",   3'b001, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    step("sel_sw",      3'b010, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b10, 4'h0, 4'h0, 1'b0, 2'b00);
    step("multi_low",   3'b110, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    step("multi_all",   3'b111, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b01, 4'h0, 4'h0, 1'b0, 2'b00);
    step("edit_rise",   3'b000, 1'b1, 4'h0,    1'b0, 1'b0, 1'b0,   2'b01, 4'h2, 4'h0, 1'b0, 2'b00);
    step("edit_nav",    3'b010, 1'b1, 4'h2,    1'b0, 1'b0, 1'b0,   2'b01, 4'h2, 4'h2, 1'b0, 2'b00);
    step("edit_hold",   3'b000, 1'b1, 4'h0,    1'b0, 1'b0, 1'b0,   2'b01, 4'h2, 4'h0, 1'b0, 2'b00);
    step("edit_fall",   3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b01, 4'h0, 4'h0, 1'b0, 2'b00);
    step("nav_gated",   3'b000, 1'b0, 4'h1,    1'b0, 1'b0, 1'b0,   2'b01, 4'h0, 4'h0, 1'b0, 2'b00);
    step("tmr_to_sw",   3'b010, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b10, 4'h0, 4'h0, 1'b0, 2'b00);
    step("sw_nav",      3'b000, 1'b0, 4'h4,    1'b0, 1'b0, 1'b0,   2'b10, 4'h0, 4'h4, 1'b0, 2'b00);
    step("sw_no_edit",  3'b000, 1'b1, 4'h0,    1'b0, 1'b0, 1'b0,   2'b10, 4'h0, 4'h0, 1'b0, 2'b00);
    step("alm_enter",   3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b1,   2'b11, 4'h0, 4'h0, 1'b1, 2'b10);
    step("alm_tick1",   3'b000, 1'b0, 4'h0,    1'b1, 1'b0, 1'b0,   2'b11, 4'h0, 4'h0, 1'b1, 2'b10);
    step("alm_idle",    3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b11, 4'h0, 4'h0, 1'b1, 2'b10);
    step("alm_tick2",   3'b000, 1'b0, 4'h0,    1'b1, 1'b0, 1'b0,   2'b11, 4'h0, 4'h0, 1'b1, 2'b10);
    step("alm_tick3",   3'b000, 1'b0, 4'h0,    1'b1, 1'b0, 1'b0,   2'b10, 4'h0, 4'h0, 1'b0, 2'b00);
    step("sw_back",     3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b10, 4'h0, 4'h0, 1'b0, 2'b00);
    step("both_evt",    3'b000, 1'b0, 4'h0,    1'b0, 1'b1, 1'b1,   2'b11, 4'h0, 4'h0, 1'b1, 2'b10);
    step("nav_ack",     3'b000, 1'b0, 4'h1,    1'b0, 1'b0, 1'b0,   2'b10, 4'h0, 4'h0, 1'b0, 2'b00);
    step("tmr_alert",   3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b01, 4'h0, 4'h0, 1'b1, 2'b01);
    step("tmr_t1_alm",  3'b000, 1'b0, 4'h0,    1'b1, 1'b0, 1'b1,   2'b01, 4'h0, 4'h0, 1'b1, 2'b01);
    step("tmr_reload",  3'b000, 1'b0, 4'h0,    1'b0, 1'b1, 1'b0,   2'b01, 4'h0, 4'h0, 1'b1, 2'b01);
    step("tmr_t2",      3'b000, 1'b0, 4'h0,    1'b1, 1'b0, 1'b0,   2'b01, 4'h0, 4'h0, 1'b1, 2'b01);
    step("tmr_t3",      3'b000, 1'b0, 4'h0,    1'b1, 1'b0, 1'b0,   2'b01, 4'h0, 4'h0, 1'b1, 2'b01);
    step("tmr_expire",  3'b000, 1'b0, 4'h0,    1'b1, 1'b0, 1'b0,   2'b10, 4'h0, 4'h0, 1'b0, 2'b00);
    step("alm_pending", 3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b11, 4'h0, 4'h0, 1'b1, 2'b10);
    step("mode_ack",    3'b001, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b10, 4'h0, 4'h0, 1'b0, 2'b00);
    step("sw_to_clk",   3'b010, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    step("clk_edit",    3'b000, 1'b1, 4'h0,    1'b0, 1'b0, 1'b0,   2'b00, 4'h1, 4'h0, 1'b0, 2'b00);
    step("edit_alarm",  3'b000, 1'b1, 4'h0,    1'b0, 1'b0, 1'b1,   2'b00, 4'h1, 4'h0, 1'b0, 2'b00);
    step("edit_hold2",  3'b000, 1'b1, 4'h0,    1'b0, 1'b0, 1'b0,   2'b00, 4'h1, 4'h0, 1'b0, 2'b00);
    step("edit_rel",    3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    step("late_alert",  3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b11, 4'h0, 4'h0, 1'b1, 2'b10);
    step("pend_tmr",    3'b000, 1'b0, 4'h0,    1'b0, 1'b1, 1'b0,   2'b11, 4'h0, 4'h0, 1'b1, 2'b10);

    // Asynchronous reset in the middle of an ALERT with a timer request pending.
    rst = 1'b1;
    #2;
    push_exp("async_rst", 2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    pop_cmp();
    @(posedge clk);
    #1;
    push_exp("rst_hold", 2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    pop_cmp();
    rst = 1'b0;

    step("no_pend1",    3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    step("no_pend2",    3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    step("alert_wins",  3'b001, 1'b0, 4'h0,    1'b0, 1'b0, 1'b1,   2'b11, 4'h0, 4'h0, 1'b1, 2'b10);
    step("ack_to_clk",  3'b100, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    step("sel_alm",     3'b100, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b11, 4'h0, 4'h0, 1'b0, 2'b00);
    step("alm_edit",    3'b000, 1'b1, 4'h0,    1'b0, 1'b0, 1'b0,   2'b11, 4'h8, 4'h0, 1'b0, 2'b00);
    step("alm_nav",     3'b000, 1'b1, 4'h8,    1'b0, 1'b0, 1'b0,   2'b11, 4'h8, 4'h8, 1'b0, 2'b00);
    step("alm_rel",     3'b000, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0,   2'b11, 4'h0, 4'h0, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
